// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues in-order word reads over a valid/ready request
// channel, buffers returned words with their PCs in a small FIFO, and presents
// them to decode under valid/ready. A redirect taken by decode flushes the FIFO
// and discards responses still in flight.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   next_PC_select        redirect request from decode
//   target_PC             redirect destination
//   dec_ready             decode accepts the presented instruction
//   PC, instruction       presented instruction (NOP and rsp_PC when empty)
//   inst_valid            PC/instruction are valid
//   imem_req_valid/addr   fetch request to instruction memory
//   imem_req_ready        memory accepts the request
//   imem_rsp_valid/data   in-order response word
module fetch_unit #(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    dec_ready,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction,
    output logic                    inst_valid,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data
);

    localparam int unsigned AW = ADDRESS_BITS;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [AW-1:0] STEP = AW'(4);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   word;
    } entry_t;

    // Architectural state
    logic [AW-1:0] fetch_pc_q, fetch_pc_n;
    logic [AW-1:0] rsp_pc_q, rsp_pc_n;
    logic [CW-1:0] inflight_q, inflight_n;
    logic [CW-1:0] drop_q, drop_n;
    logic [CW-1:0] count_q, count_n;
    logic [PW-1:0] rd_q, rd_n;
    logic [PW-1:0] wr_q, wr_n;
    entry_t        fifo_q [DEPTH];

    // Registered presentation of the FIFO head and request credit
    entry_t        head_q, head_n;
    logic          valid_q, valid_n;
    logic          credit_q, credit_n;

    // Per-cycle events
    logic          accept;
    logic          pop;
    logic          redirect;
    logic          rsp;
    logic          drop_hit;
    logic          push;
    logic [CW-1:0] remain;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit register resets high so a request leaves in the first cycle
    // after release; the reset term keeps the request low while in reset.
    assign imem_req_valid = credit_q & reset;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = valid_q;
    assign PC             = head_q.pc;
    assign instruction    = head_q.word;

    // Next-state computation
    always_comb begin
        accept     = imem_req_valid & imem_req_ready;
        pop        = valid_q & dec_ready;
        redirect   = pop & next_PC_select;
        rsp        = imem_rsp_valid & (inflight_q != '0);
        drop_hit   = rsp & (drop_q != '0);
        // A response landing in the redirect cycle is stale as well.
        push       = rsp & ~drop_hit & ~redirect;

        inflight_n = inflight_q + CW'(accept) - CW'(rsp);
        remain     = count_q - CW'(pop);

        fetch_pc_n = fetch_pc_q;
        rsp_pc_n   = rsp_pc_q;
        drop_n     = drop_q - CW'(drop_hit);
        count_n    = remain + CW'(push);
        rd_n       = pop  ? ptr_inc(rd_q) : rd_q;
        wr_n       = push ? ptr_inc(wr_q) : wr_q;

        if (accept) begin
            fetch_pc_n = fetch_pc_q + STEP;
        end
        if (push) begin
            rsp_pc_n = rsp_pc_q + STEP;
        end

        // Everything still in flight after this edge, including a request
        // accepted right now, belongs to the abandoned path.
        if (redirect) begin
            fetch_pc_n = target_PC;
            rsp_pc_n   = target_PC;
            drop_n     = inflight_n;
            count_n    = '0;
            rd_n       = '0;
            wr_n       = '0;
        end

        // Head after this edge: the pushed word if the FIFO drains to it,
        // otherwise the stored entry at the new read pointer.
        valid_n = (count_n != '0);
        head_n  = '{pc: rsp_pc_n, word: NOP};
        if (valid_n) begin
            if (remain == '0) begin
                head_n = '{pc: rsp_pc_q, word: imem_rsp_data};
            end else begin
                head_n = fifo_q[rd_n];
            end
        end

        occupancy = {1'b0, inflight_n} + {1'b0, count_n};
        credit_n  = (occupancy < (CW + 1)'(DEPTH));
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            head_q     <= '{pc: RESET_PC, word: NOP};
            valid_q    <= 1'b0;
            credit_q   <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_n;
            rsp_pc_q   <= rsp_pc_n;
            inflight_q <= inflight_n;
            drop_q     <= drop_n;
            count_q    <= count_n;
            rd_q       <= rd_n;
            wr_q       <= wr_n;
            head_q     <= head_n;
            valid_q    <= valid_n;
            credit_q   <= credit_n;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_q] <= '{pc: rsp_pc_q, word: imem_rsp_data};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (DEPTH=2,
// RESET_PC=0) with a single-cycle instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        dec_ready;
    logic [15:0] PC;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] exp_pc;
    logic [15:0] hold_addr;

    fetch_unit #(.ADDRESS_BITS(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .dec_ready      (dec_ready),
        .PC             (PC),
        .instruction    (instruction),
        .inst_valid     (inst_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Single-cycle memory: answers every accepted request on the next cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            imem_rsp_valid <= imem_req_valid && imem_req_ready;
            imem_rsp_data  <= word_of(imem_req_addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Check each cycle's presentation against the expected PC stream.
    task automatic stream(input int n);
        int got;
        got = 0;
        for (int i = 0; i < n; i++) begin
            if (inst_valid) begin
                chk("stream_pc", 32'(PC), 32'(exp_pc));
                chk("stream_word", instruction, word_of(exp_pc));
                exp_pc = exp_pc + 16'd4;
                got++;
            end else begin
                chk("stream_nop", instruction, NOP);
            end
            step();
        end
        chk("stream_progress", 32'(got * 3 >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin
                found = 1;
                break;
            end
            step();
        end
        chk("wait_valid", 32'(found), 32'd1);
    endtask

    // Stream until the given PC is presented; stop on that cycle.
    task automatic wait_head(input logic [15:0] pc);
        int found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid) begin
                chk("head_pc", 32'(PC), 32'(exp_pc));
                chk("head_word", instruction, word_of(exp_pc));
                if (PC == pc) begin
                    found = 1;
                    break;
                end
                exp_pc = exp_pc + 16'd4;
            end
            step();
        end
        chk("wait_head", 32'(found), 32'd1);
    endtask

    // Take a redirect on the next valid cycle and check its timing.
    task automatic do_redirect(input logic [15:0] tgt);
        wait_valid();
        next_PC_select = 1'b1;
        target_PC      = tgt;
        step();
        next_PC_select = 1'b0;
        chk("redir_flush", 32'(inst_valid), 32'd0);
        chk("redir_pc", 32'(PC), 32'(tgt));
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", 32'(imem_req_addr), 32'(tgt));
        step();
        chk("redir_gap", 32'(inst_valid), 32'd0);
        step();
        chk("redir_tgt_valid", 32'(inst_valid), 32'd1);
        chk("redir_tgt_pc", 32'(PC), 32'(tgt));
        chk("redir_tgt_word", instruction, word_of(tgt));
        exp_pc = tgt + 16'd4;
        step();
    endtask

    initial begin
        reset          = 1'b0;
        next_PC_select = 1'b0;
        target_PC      = '0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Release just after an edge; first request leaves immediately.
        reset          = 1'b1;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_req_addr", 32'(imem_req_addr), 32'h0);
        step();
        chk("c1_valid", 32'(inst_valid), 32'd0);
        chk("c1_nop", instruction, NOP);
        chk("c1_req_addr", 32'(imem_req_addr), 32'h4);
        step();
        chk("c2_valid", 32'(inst_valid), 32'd1);
        chk("c2_pc", 32'(PC), 32'h0);
        chk("c2_word", instruction, word_of(16'h0000));
        step();
        chk("c3_pc", 32'(PC), 32'h4);

        // Backpressure for 5 cycles with 0x0004 at the head
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_pc", 32'(PC), 32'h4);
            if (i == 4) begin
                chk("bp_count", 32'(dut.count_q), 32'd2);
                chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
            end
            step();
        end
        dec_ready = 1'b1;
        exp_pc    = 16'h0004;
        stream(12);

        // Redirect to 0x0100, stream up to 0x0114, then take the JAL
        do_redirect(16'h0100);
        wait_head(16'h0114);
        next_PC_select = 1'b1;
        target_PC      = 16'h0128;
        step();
        // Still asserted while nothing is valid: must be ignored.
        target_PC = 16'h0200;
        chk("jal_flush", 32'(inst_valid), 32'd0);
        chk("jal_pc", 32'(PC), 32'h0128);
        chk("jal_req_addr", 32'(imem_req_addr), 32'h0128);
        step();
        chk("ign_inv_valid", 32'(inst_valid), 32'd0);
        chk("ign_inv_addr", 32'(imem_req_addr), 32'h012C);
        step();
        next_PC_select = 1'b0;
        chk("jal_tgt_valid", 32'(inst_valid), 32'd1);
        chk("jal_tgt_pc", 32'(PC), 32'h0128);
        chk("jal_tgt_word", instruction, word_of(16'h0128));
        exp_pc = 16'h012C;
        step();

        // Redirect ignored while decode is not ready
        wait_head(16'h012C);
        dec_ready      = 1'b0;
        next_PC_select = 1'b1;
        target_PC      = 16'h0300;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ign_nr_valid", 32'(inst_valid), 32'd1);
            chk("ign_nr_pc", 32'(PC), 32'h012C);
        end
        next_PC_select = 1'b0;
        dec_ready      = 1'b1;
        stream(6);

        // Memory stalls three cycles with a redirect to 0x0154 in between
        wait_valid();
        hold_addr      = imem_req_addr;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        step();
        chk("stall_addr_hold", 32'(imem_req_addr), 32'(hold_addr));
        chk("stall_valid", 32'(inst_valid), 32'd1);
        next_PC_select = 1'b1;
        dec_ready      = 1'b1;
        target_PC      = 16'h0154;
        step();
        next_PC_select = 1'b0;
        chk("stall_redir_addr", 32'(imem_req_addr), 32'h0154);
        chk("stall_redir_req", 32'(imem_req_valid), 32'd1);
        chk("stall_redir_flush", 32'(inst_valid), 32'd0);
        step();
        imem_req_ready = 1'b1;
        chk("stall_addr_keep", 32'(imem_req_addr), 32'h0154);
        exp_pc = 16'h0154;
        stream(10);

        // Address wrap
        do_redirect(16'hFFF8);
        stream(8);
        chk("wrap_reached", 32'(exp_pc < 16'h0100), 32'd1);

        // Asynchronous reset mid-cycle
        wait_valid();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_pc", 32'(PC), 32'h0);
        chk("arst_instr", instruction, NOP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
